// File: rtl/prbs5_checker_pkg.sv
// ============================================================
// prbs_pkg : shared types and constants for the PRBS5 checker
// Rev 1.0
// ============================================================
`default_nettype none

package prbs_pkg;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int PRBS_LEN = 5;
  // Taps of x^5 + x^3 + 1 expressed as history-register indices (sr[0] newest)
  localparam int TAP_A    = 4;
  localparam int TAP_B    = 2;

  // The LFSR can never leave this state, so it is never a valid lock point
  localparam logic [PRBS_LEN-1:0] ZERO_SEED = '0;

endpackage

`default_nettype wire

// File: rtl/prbs5_checker_if.sv
// ============================================================
// prbs5_checker_if : recovered-bit input and status/counter outputs
// Rev 1.0
// ============================================================
`default_nettype none

interface prbs5_checker_if #(
  parameter int CNT_W = 32
);

  logic             i_en;
  logic             i_bit;
  logic             i_clr;
  logic             o_lock;
  logic             o_err;
  logic [CNT_W-1:0] o_bit_cnt;
  logic [CNT_W-1:0] o_err_cnt;

  modport master (
    output i_en, i_bit, i_clr,
    input  o_lock, o_err, o_bit_cnt, o_err_cnt
  );

  modport slave (
    input  i_en, i_bit, i_clr,
    output o_lock, o_err, o_bit_cnt, o_err_cnt
  );

endinterface

`default_nettype wire

// File: rtl/prbs5_checker_loss_monitor.sv
// ============================================================
// prbs_loss_monitor : windowed error count, flags loss of lock
// Rev 1.0
// ============================================================
`default_nettype none

module prbs_loss_monitor
  import prbs_pkg::*;
#(
  parameter int WIN      = 64,
  parameter int LOSS_THR = 8
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic step,
  input  wire logic err,
  input  wire logic restart,
  output logic      loss
);

  localparam int c_IDX_W = $clog2(WIN);
  localparam int c_ERR_W = $clog2(WIN + 1);
  localparam logic [c_IDX_W-1:0] c_WIN_LAST = c_IDX_W'(WIN - 1);
  localparam logic [c_ERR_W-1:0] c_THR      = c_ERR_W'(LOSS_THR);

  logic [c_IDX_W-1:0] r_win_idx;
  logic [c_ERR_W-1:0] r_win_err;
  logic [c_ERR_W-1:0] w_err_sum;

  // win_err stays below LOSS_THR <= WIN, so the +1 always fits
  assign w_err_sum = r_win_err + c_ERR_W'(err);
  assign loss      = step && (w_err_sum >= c_THR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_idx <= '0;
      r_win_err <= '0;
    end else if (restart) begin
      r_win_idx <= '0;
      r_win_err <= '0;
    end else if (step) begin
      if (loss || (r_win_idx == c_WIN_LAST)) begin
        r_win_idx <= '0;
        r_win_err <= '0;
      end else begin
        r_win_idx <= r_win_idx + c_IDX_W'(1);
        r_win_err <= w_err_sum;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/prbs5_checker.sv
// ============================================================
// prbs5_checker : self-synchronising PRBS5 receive checker
// Rev 1.0
// ============================================================
`default_nettype none

module prbs5_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int WIN      = 64,
  parameter int LOSS_THR = 8,
  parameter int CNT_W    = 32
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  prbs5_checker_if.slave   bus
);

  localparam logic [7:0] c_LOCK     = 8'(LOCK_CNT);
  localparam logic [2:0] c_FILL_MAX = 3'(PRBS_LEN);

  state_t              r_state;
  logic [PRBS_LEN-1:0] r_sr;
  logic [2:0]          r_fill;
  logic [7:0]          r_match;
  logic                r_lock;
  logic                r_err;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [CNT_W-1:0]    r_err_cnt;

  logic       w_exp;
  logic       w_mis;
  logic       w_step;
  logic       w_lock_now;
  logic       w_loss;
  logic [7:0] w_match_nxt;

  assign w_exp       = r_sr[TAP_A] ^ r_sr[TAP_B];
  assign w_mis       = bus.i_bit ^ w_exp;
  assign w_step      = bus.i_en && (r_state == LOCKED);
  assign w_match_nxt = r_match + 8'd1;
  assign w_lock_now  = bus.i_en && (r_state == SEARCH) && (r_fill == c_FILL_MAX)
                       && (r_sr != ZERO_SEED) && !w_mis && (w_match_nxt == c_LOCK);

  prbs_loss_monitor #(
    .WIN      (WIN),
    .LOSS_THR (LOSS_THR)
  ) u_loss_monitor (
    .clk     (clk),
    .rst_n   (rst_n),
    .step    (w_step),
    .err     (w_mis),
    .restart (w_lock_now),
    .loss    (w_loss)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SEARCH;
      r_sr      <= ZERO_SEED;
      r_fill    <= '0;
      r_match   <= '0;
      r_lock    <= 1'b0;
      r_err     <= 1'b0;
      r_bit_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_step && w_mis;

      // A clear on the same cycle as a counted bit drops that bit
      if (bus.i_clr) begin
        r_bit_cnt <= '0;
        r_err_cnt <= '0;
      end else if (w_step) begin
        if (r_bit_cnt != '1)
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        if (w_mis && (r_err_cnt != '1))
          r_err_cnt <= r_err_cnt + CNT_W'(1);
      end

      if (bus.i_en) begin
        case (r_state)
          SEARCH: begin
            r_sr <= {r_sr[PRBS_LEN-2:0], bus.i_bit};
            if (r_fill < c_FILL_MAX) begin
              r_fill <= r_fill + 3'd1;
            end else if (r_sr == ZERO_SEED) begin
              r_match <= '0;
            end else if (!w_mis) begin
              r_match <= w_match_nxt;
              if (w_match_nxt == c_LOCK) begin
                r_state <= LOCKED;
                r_lock  <= 1'b1;
              end
            end else begin
              r_match <= '0;
            end
          end
          LOCKED: begin
            // Flywheel on the prediction so a bad bit cannot corrupt history
            r_sr <= {r_sr[PRBS_LEN-2:0], w_exp};
            if (w_loss) begin
              r_state <= SEARCH;
              r_lock  <= 1'b0;
              r_fill  <= '0;
              r_match <= '0;
            end
          end
          default: begin
            r_state <= SEARCH;
            r_lock  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_lock    = r_lock;
  assign bus.o_err     = r_err;
  assign bus.o_bit_cnt = r_bit_cnt;
  assign bus.o_err_cnt = r_err_cnt;

endmodule

`default_nettype wire
